// File: rtl/aes_ahb_slave.sv
// AHB-lite slave front end of the AES accelerator.
// It decodes CPU register accesses, buffers four input words for the controller
// and four result words for CPU readback, and answers errors with a two-cycle ERROR response.
module aes_ahb_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [3:0]  haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  input  logic        ahb_mode,
  input  logic        ahb_shift_en,
  input  logic        done_chg_key,
  input  logic [31:0] tx_word,
  output logic        start,
  output logic        data_type,
  output logic        enc_dec,
  output logic        data_received,
  output logic [31:0] rx_word
);

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_WDATA  = 2'd1;
  localparam logic [1:0] REG_RDATA  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  typedef enum logic {RESP_OKAY, RESP_ERR2} resp_state_t;

  resp_state_t resp_state, resp_next;

  logic        pend_q;
  logic [1:0]  addr_q;
  logic        write_q;
  logic [2:0]  size_q;

  logic [31:0] in_mem  [4];
  logic [31:0] out_mem [4];
  logic [1:0]  in_rd, in_wr, out_rd, out_wr;
  logic [2:0]  in_count, out_count, out_count_nxt;

  logic        key_done_q, busy_q, err_q;
  logic        accept, xfer_err, cmd_wr, in_push, in_pop, out_push, out_pop;
  logic        in_full, out_full;
  logic [31:0] status_word;
  logic        unused_bits;

  // Byte-lane address bits and the SEQ/NONSEQ distinction carry no meaning here.
  assign unused_bits = &{1'b0, haddr[1:0], htrans[0]};

  assign accept        = hsel & htrans[1] & hready;
  assign in_full       = (in_count == 3'd4);
  assign out_full      = (out_count == 3'd4);
  assign data_received = in_full;
  assign rx_word       = (in_count != 3'd0) ? in_mem[in_rd] : 32'd0;
  assign status_word   = {27'd0, err_q, busy_q, key_done_q, out_full, in_full};

  // Register the address phase so the data phase can be decoded one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      addr_q  <= 2'd0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      pend_q <= accept;
      if (accept) begin
        addr_q  <= haddr[3:2];
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  // Data-phase decode: detect illegal accesses and qualify the legal side effects.
  always_comb begin
    xfer_err = 1'b0;
    if (pend_q) begin
      if (size_q != SIZE_WORD)                              xfer_err = 1'b1;
      if (write_q && addr_q[1])                             xfer_err = 1'b1;
      if (!write_q && !addr_q[1])                           xfer_err = 1'b1;
      if (write_q && addr_q == REG_WDATA && in_full)        xfer_err = 1'b1;
      if (!write_q && addr_q == REG_RDATA && out_count == 3'd0) xfer_err = 1'b1;
    end
    cmd_wr   = pend_q && !xfer_err && write_q && addr_q == REG_CMD;
    in_push  = pend_q && !xfer_err && write_q && addr_q == REG_WDATA;
    out_pop  = pend_q && !xfer_err && !write_q && addr_q == REG_RDATA;
    in_pop   = !ahb_mode && ahb_shift_en && in_count != 3'd0;
    out_push = ahb_mode && ahb_shift_en && !out_full;
    out_count_nxt = out_count + {2'd0, out_push} - {2'd0, out_pop};
  end

  // Read data is driven straight from the registered address during the data phase.
  always_comb begin
    hrdata = 32'd0;
    if (pend_q && !write_q && !xfer_err) begin
      case (addr_q)
        REG_RDATA:  hrdata = out_mem[out_rd];
        REG_STATUS: hrdata = status_word;
        default:    hrdata = 32'd0;
      endcase
    end
  end

  // Response state register.
  always_ff @(posedge clk) begin
    if (rst) resp_state <= RESP_OKAY;
    else     resp_state <= resp_next;
  end

  // Response outputs: the first error cycle stalls, the second completes with ERROR.
  always_comb begin
    resp_next = resp_state;
    hready    = 1'b1;
    hresp     = 1'b0;
    case (resp_state)
      RESP_OKAY: begin
        if (xfer_err) begin
          hready    = 1'b0;
          hresp     = 1'b1;
          resp_next = RESP_ERR2;
        end
      end
      RESP_ERR2: begin
        hresp     = 1'b1;
        resp_next = RESP_OKAY;
      end
      default: resp_next = RESP_OKAY;
    endcase
  end

  // Buffer storage; stale words are never visible because counts gate every read.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr]   <= hwdata;
    if (out_push) out_mem[out_wr] <= tx_word;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_rd     <= 2'd0;
      in_wr     <= 2'd0;
      in_count  <= 3'd0;
      out_rd    <= 2'd0;
      out_wr    <= 2'd0;
      out_count <= 3'd0;
    end else begin
      if (in_push)  in_wr  <= in_wr + 2'd1;
      if (in_pop)   in_rd  <= in_rd + 2'd1;
      if (out_push) out_wr <= out_wr + 2'd1;
      if (out_pop)  out_rd <= out_rd + 2'd1;
      in_count  <= in_count + {2'd0, in_push} - {2'd0, in_pop};
      out_count <= out_count_nxt;
    end
  end

  // Command register, start pulse and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      start      <= 1'b0;
      data_type  <= 1'b0;
      enc_dec    <= 1'b0;
      key_done_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      start <= cmd_wr;
      if (cmd_wr) begin
        data_type  <= hwdata[0];
        enc_dec    <= hwdata[1];
        key_done_q <= 1'b0;
        busy_q     <= 1'b1;
        err_q      <= 1'b0;
      end else begin
        if (xfer_err)     err_q      <= 1'b1;
        if (done_chg_key) key_done_q <= 1'b1;
        if (data_type && done_chg_key)
          busy_q <= 1'b0;
        if (!data_type && !out_full && out_count_nxt == 3'd4)
          busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/aes_ahb_slave.md
# aes_ahb_slave

AHB-lite slave front end of the AES accelerator, and the responder to the AES controller's command interface. It accepts CPU commands, key words and data words over a 32-bit AHB-lite bus, and raises `start`, `data_type`, `enc_dec` and `data_received` toward the controller. It buffers four input words (128 bits) that the controller shifts out, and four result words that the controller shifts in for CPU readback. It sits between the system bus and the controller / GenKey / AESctr datapath.

## Interface
Parameters:
- none. Bus width is 32; buffer depth is 4 words, fixed.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- hsel  in  1  slave select
- haddr  in  4  byte address; bits [3:2] decoded
- htrans  in  2  transfer type; bit1 = NONSEQ/SEQ
- hwrite  in  1  1 = write
- hsize  in  3  must be 3'b010 (word)
- hwdata  in  32  write data (data phase)
- hrdata  out  32  read data (data phase)
- hready  out  1  transfer done
- hresp  out  1  1 = ERROR
- ahb_mode  in  1  from controller: 0 = shift input buffer out, 1 = capture result
- ahb_shift_en  in  1  from controller: perform one shift in `ahb_mode` direction
- done_chg_key  in  1  from controller: key stored
- tx_word  in  32  result word from datapath
- start  out  1  one-cycle command pulse to controller
- data_type  out  1  1 = key load, 0 = data
- enc_dec  out  1  0 = encrypt, 1 = decrypt
- data_received  out  1  input buffer holds 4 words
- rx_word  out  32  oldest input word

## Operation
- Register map by haddr[3:2]:
  - 0 CMD (W): bit0 → data_type, bit1 → enc_dec. Clears the sticky bits and sets busy.
  - 1 WDATA (W): push to the input FIFO.
  - 2 RDATA (R): pop the output FIFO.
  - 3 STATUS (R): bit0 in_full, bit1 out_full, bit2 key_done, bit3 busy, bit4 err; all other bits 0.
- Address phase is accepted when hsel & htrans[1] & hready. addr, hwrite and hsize are registered, and a pending flag is set for the next cycle (data phase).
- Input FIFO: 4×32, count 0..4.
  - WDATA push increments the count.
  - Controller pop (ahb_mode=0, ahb_shift_en, count>0) decrements it.
  - A push and a pop in the same cycle leave the count unchanged; both take effect.
  - rx_word = oldest word, or 0 when empty. A pop when empty is ignored.
- Output FIFO: 4×32.
  - Controller capture (ahb_mode=1, ahb_shift_en, count<4) pushes tx_word.
  - RDATA pops. Capture plus pop in the same cycle leaves the count unchanged.
  - A capture when full is ignored.
- data_received = (in_count==4).
- key_done: set by done_chg_key; cleared by a CMD write.
- busy:
  - Set by a CMD write.
  - Cleared by done_chg_key when data_type=1, or by out_count reaching 4 when data_type=0.
- Data-phase error conditions:
  - hsize≠word
  - write to RDATA or STATUS
  - read of CMD or WDATA
  - WDATA write with in_count==4
  - RDATA read with out_count==0
- An erroring transfer has no side effect and sets sticky err (cleared by a CMD write).
- Response FSM:
  - OKAY: hready=1, hresp=0.
  - On a pending transfer that meets an error condition: that cycle drives hready=0, hresp=1, then the FSM goes to ERR2.
  - ERR2: hready=1, hresp=1, then back to OKAY.
  - No address phase is accepted while hready=0.

## Timing
- Reset values: hrdata 0, hready 1, hresp 0, start 0, data_type 0, enc_dec 0, data_received 0, rx_word 0. Both FIFOs are empty, all status bits are 0, and the FSM is in OKAY.
- Register writes take hwdata in data-phase cycle N and are visible in cycle N+1.
- start is high in cycle N+1 only, with data_type and enc_dec already updated in N+1.
- Reads: hrdata is combinational in data-phase cycle N from the registered address. An RDATA pop commits at the end of N.
- Back-to-back transfers need zero wait states. The second transfer's data phase sees counts updated by the first.
- Error response is exactly 2 cycles.
- rst in mid-transfer or mid-error returns every output to its reset value on the next edge. Buffered words are discarded.

## Test plan
- Reset → hready=1, hresp=0, start=0, STATUS reads 0x0.
- Write CMD=0x3 → start high for 1 cycle in N+1; data_type=1, enc_dec=1; STATUS bit3=1.
- Four back-to-back WDATA writes 0x11111111..0x44444444 → data_received=1; controller shifts 4× with ahb_mode=0 → rx_word sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444; data_received=0.
- Fifth WDATA write while full → hready=0/hresp=1, then hready=1/hresp=1; STATUS bit4=1; FIFO contents unchanged.
- Controller captures tx_word 0xA0..0xA3 → STATUS bit1=1, busy=0; four RDATA reads return 0xA0..0xA3; a fifth read returns the 2-cycle ERROR.
- WDATA push simultaneous with controller pop at count=2 → count stays 2; assert rst mid-sequence → all outputs return to reset values on the next cycle.
